// File: rtl/key_check_seq.sv
// Sequential key comparator behind an HLS-style ap_ctrl_hs handshake.
// Compares locking_key against golden_key one CHUNK_W-bit slice per cycle.
module key_check_seq #(
  parameter int KEY_W   = 12287,
  parameter int CHUNK_W = 64,
  parameter int RET_W   = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  output logic [RET_W-1:0] ap_return,
  input  logic             mode,
  input  logic [KEY_W-1:0] locking_key,
  input  logic [KEY_W-1:0] golden_key
);

  localparam int N     = (KEY_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W = N * CHUNK_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int OFF_W = (PAD_W > 1) ? $clog2(PAD_W) : 1;
  localparam int CNT_W = $clog2(CHUNK_W + 1);
  localparam int SUM_W = ((RET_W > CNT_W) ? RET_W : CNT_W) + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [RET_W-1:0] RET_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RET_W-1:0]   acc_q, acc_d;
  logic [RET_W-1:0]   ret_q, ret_d;
  logic               mode_q, mode_d;

  logic [PAD_W-1:0]   diff_pad;
  logic [OFF_W-1:0]   offset;
  logic [CHUNK_W-1:0] slice;
  logic [CNT_W-1:0]   slice_cnt;
  logic [SUM_W-1:0]   sum;
  logic [RET_W-1:0]   acc_sat;
  logic               last_slice;
  logic               early_exit;

  function automatic logic [CNT_W-1:0] popcount(input logic [CHUNK_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // Zero-extending the XOR pads the last slice with matching bits, so
  // padding can never register as a mismatch.
  assign diff_pad  = PAD_W'(locking_key ^ golden_key);
  assign offset    = OFF_W'(idx_q) * OFF_W'(CHUNK_W);
  assign slice     = diff_pad[offset +: CHUNK_W];
  assign slice_cnt = popcount(slice);

  // One extra bit of headroom lets the add detect overflow before saturating.
  assign sum     = SUM_W'(acc_q) + SUM_W'(slice_cnt);
  assign acc_sat = (sum > SUM_W'(RET_MAX)) ? RET_MAX : RET_W'(sum);

  assign last_slice = (idx_q == LAST_IDX);
  assign early_exit = !mode_q && (slice_cnt != '0);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ret_d   = ret_q;
    mode_d  = mode_q;

    unique case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          state_d = S_RUN;
          idx_d   = '0;
          acc_d   = '0;
          mode_d  = mode;
        end
      end

      S_RUN: begin
        acc_d = acc_sat;
        idx_d = idx_q + IDX_W'(1);
        if (early_exit || last_slice) begin
          state_d = S_DONE;
          ret_d   = mode_q ? acc_sat : RET_W'(acc_sat == '0);
        end
      end

      S_DONE: begin
        if (ap_start) begin
          state_d = S_RUN;
          idx_d   = '0;
          acc_d   = '0;
          mode_d  = mode;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
      mode_q  <= mode_d;
    end
  end

  assign ap_idle   = (state_q == S_IDLE);
  assign ap_done   = (state_q == S_DONE);
  assign ap_ready  = (state_q == S_DONE);
  assign ap_return = ret_q;

endmodule

// File: tb/tb_key_check_seq.sv
// Directed self-checking bench for key_check_seq at default parameters.
// Cycle c is observed on the falling edge before rising edge c.
module tb_key_check_seq;

  localparam int KEY_W   = 12287;
  localparam int CHUNK_W = 64;
  localparam int RET_W   = 32;
  localparam int FULL    = 193;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [RET_W-1:0] ap_return;
  logic             mode;
  logic [KEY_W-1:0] locking_key;
  logic [KEY_W-1:0] golden_key;
  logic [KEY_W-1:0] eq_key;

  int n_checks = 0;
  int n_pass   = 0;

  key_check_seq #(.KEY_W(KEY_W), .CHUNK_W(CHUNK_W), .RET_W(RET_W)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .ap_start   (ap_start),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .ap_ready   (ap_ready),
    .ap_return  (ap_return),
    .mode       (mode),
    .locking_key(locking_key),
    .golden_key (golden_key)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drive a start so that it is sampled at the next rising edge (cycle 0).
  task automatic do_start(input logic m, input logic hold);
    @(negedge ap_clk);
    mode     = m;
    ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    if (!hold) ap_start = 1'b0;
  endtask

  // Called just after the cycle-0 edge; returns the cycle of ap_done (-1 if
  // never seen) and how many cycles ap_idle was high before it.
  task automatic run_wait(input int limit, output int done_cyc, output int idle_cnt);
    done_cyc = -1;
    idle_cnt = 0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge ap_clk);
      if (ap_done) begin
        done_cyc = c;
        break;
      end
      if (ap_idle) idle_cnt++;
      @(posedge ap_clk);
    end
  endtask

  task automatic full_run(input string tag, input logic m, input int exp_cyc,
                          input logic [31:0] exp_ret);
    int dc, ic;
    do_start(m, 1'b0);
    run_wait(FULL + 10, dc, ic);
    check({tag, " done cycle"}, dc, exp_cyc);
    check({tag, " ready"}, ap_ready, 1'b1);
    check({tag, " return"}, ap_return, exp_ret);
    check({tag, " idle during run"}, ic, 0);
    @(posedge ap_clk);
    @(negedge ap_clk);
    check({tag, " idle after"}, ap_idle, 1'b1);
    check({tag, " done pulse 1 cycle"}, ap_done, 1'b0);
    check({tag, " return held"}, ap_return, exp_ret);
  endtask

  initial begin
    int dc, ic, stray;
    logic [7:0] pat;
    pat = 8'hA5;
    for (int i = 0; i < KEY_W; i++) eq_key[i] = pat[i % 8];

    // 1: reset held with ap_start high
    ap_rst      = 1'b1;
    ap_start    = 1'b1;
    mode        = 1'b1;
    golden_key  = eq_key;
    locking_key = eq_key;
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    check("rst idle", ap_idle, 1'b1);
    check("rst done", ap_done, 1'b0);
    check("rst ready", ap_ready, 1'b0);
    check("rst return", ap_return, 0);
    ap_rst   = 1'b0;
    ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check("post-rst idle", ap_idle, 1'b1);

    // 2: equal keys
    full_run("eq m1", 1'b1, FULL, 0);
    full_run("eq m0", 1'b0, FULL, 1);

    // 3: differences at bits 0, 100, 12286
    locking_key = eq_key;
    locking_key[0]     = ~locking_key[0];
    locking_key[100]   = ~locking_key[100];
    locking_key[12286] = ~locking_key[12286];
    full_run("3diff m1", 1'b1, FULL, 3);
    full_run("3diff m0", 1'b0, 2, 0);

    // 4: single difference in slice 2
    locking_key = eq_key;
    locking_key[130] = ~locking_key[130];
    full_run("bit130 m0", 1'b0, 4, 0);

    // 5: back-to-back with ap_start held high
    locking_key = eq_key;
    do_start(1'b1, 1'b1);
    run_wait(FULL + 10, dc, ic);
    check("b2b first done", dc, FULL);
    check("b2b first idle", ic, 0);
    check("b2b first return", ap_return, 0);
    @(posedge ap_clk);
    run_wait(FULL + 10, dc, ic);
    check("b2b second done", dc + FULL, 2 * FULL);
    check("b2b second idle", ic, 0);
    check("b2b second return", ap_return, 0);
    ap_start = 1'b0;
    @(posedge ap_clk);

    // 6: reset mid-run; first leave a nonzero ap_return behind
    full_run("pre-abort m0", 1'b0, FULL, 1);
    locking_key[5] = ~locking_key[5];
    do_start(1'b1, 1'b0);
    repeat (49) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    @(negedge ap_clk);
    check("abort idle", ap_idle, 1'b1);
    check("abort return", ap_return, 0);
    stray = 0;
    for (int c = 0; c < 250; c++) begin
      @(negedge ap_clk);
      if (ap_done) stray++;
    end
    check("abort no done", stray, 0);
    locking_key = eq_key;
    full_run("after abort m1", 1'b1, FULL, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
